imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Write-side counterpart of the instruction memory: fills the 256-word imem with a program
//   received as a byte stream (UART RX or testbench). Packs 4 bytes into a 32-bit word and
//   issues one word write per instruction at word-aligned byte addresses (imem indexes addr[9:2]).
//   Holds the pipeline off (loading=1) from start until done.
// PARAMETERS
//   ADDR_WIDTH  8              word-index width; capacity = 2**ADDR_WIDTH words (256)
//   DATA_WIDTH  32             instruction width; fixed at 32
//   BIG_ENDIAN  1              1: first byte -> [31:24]; 0: first byte -> [7:0]
//   HALT_WORD   32'hFFFFFFFF   end-of-program marker; written, then load terminates
// PORTS
//   clk         in   1    system clock, all logic on posedge
//   reset       in   1    synchronous, active-high
//   start       in   1    pulse: begin load session (accepted in IDLE or DONE only)
//   rx_data     in   8    incoming program byte
//   rx_valid    in   1    byte strobe; byte consumed when rx_valid & rx_ready
//   rx_ready    out  1    high only in RECV state
//   wr_en       out  1    imem write strobe, one cycle per word
//   wr_addr     out  32   byte address of write = {word_idx, 2'b00}, upper bits 0
//   wr_data     out  32   word to write
//   loading     out  1    high in CLEAR/RECV/WRITE; pipeline held in reset while high
//   done        out  1    high in DONE until next start or reset
//   word_count  out  ADDR_WIDTH+1  words written in RECV/WRITE (CLEAR writes excluded)
//   overflow    out  1    sticky: word arrived with memory full; cleared by start/reset
// BEHAVIOUR
//   Reset: state=IDLE; rx_ready, wr_en, loading, done, overflow = 0; wr_addr, wr_data,
//     word_count, byte counter, word index = 0. Reset mid-session aborts immediately;
//     imem keeps whatever was already written.
//   FSM: IDLE -start-> CLEAR -> RECV <-> WRITE -> DONE -start-> CLEAR.
//     start in CLEAR/RECV/WRITE is ignored.
//   CLEAR: 2**ADDR_WIDTH cycles, wr_en=1, wr_data=0 (NOP), wr_addr steps 0,4,...,0x3FC;
//     after last entry -> RECV with word index=0, byte counter=0, word_count=0, overflow=0.
//   RECV: rx_ready=1. Each accepted byte shifts into the packing register per BIG_ENDIAN;
//     2-bit byte counter increments and wraps. On 4th byte -> WRITE next cycle.
//     Bytes with rx_valid while rx_ready=0 are dropped (no buffering).
//   WRITE: exactly one cycle, rx_ready=0. If word index < 2**ADDR_WIDTH: wr_en=1,
//     wr_addr={index,2'b00}, wr_data=packed word; index++, word_count++.
//     Latency: wr_en asserted the cycle after the 4th byte handshake.
//     If memory full (word_count == 2**ADDR_WIDTH): no write, overflow=1, -> DONE.
//     If packed word == HALT_WORD (and written): -> DONE. Else -> RECV.
//   Filling the last entry does not itself end the load; only the next word or the halt
//     word does. word_count saturates at 2**ADDR_WIDTH.
//   DONE: done=1, loading=0, rx_ready=0, wr_en=0; word_count/overflow held for inspection.
//   Partial word (1-3 bytes) pending when reset occurs: discarded, never written.
//   wr_en is never high outside CLEAR and WRITE.
// TESTING
//   1) reset, start -> 256 wr_en cycles with wr_data=0, addr 0..0x3FC, then rx_ready=1.
//   2) BIG_ENDIAN=1, bytes 20 08 00 05 -> wr_en one cycle later, addr 0, data 32'h20080005.
//   3) words 0x20080005, 0x01095020, then FF FF FF FF -> writes at 0,4,8; done=1, word_count=3.
//   4) 257 non-halt words -> 256 writes (last addr 0x3FC); 257th: no wr_en, overflow=1, done=1.
//   5) reset after 2 bytes of word 3 -> IDLE, all outputs 0; new start re-clears, word 0 at addr 0.
//   6) rx_valid held high in CLEAR/WRITE/DONE, start pulsed in RECV -> bytes dropped, FSM unchanged.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: clears the imem, then packs a byte stream into 32-bit words
// and writes them at word-aligned byte addresses until the halt word or a full memory.
module imem_loader #(
    parameter int unsigned            ADDR_WIDTH = 8,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter bit                     BIG_ENDIAN = 1'b1,
    parameter logic [DATA_WIDTH-1:0]  HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    output logic                  wr_en_o,
    output logic [31:0]           wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  loading_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH:0]   word_count_o,
    output logic                  overflow_o
);

    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [1:0]              bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0]   pack_q, pack_d;
    logic [ADDR_WIDTH:0]     wcnt_q, wcnt_d;
    logic                    ovf_q, ovf_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            bcnt_q  <= '0;
            pack_q  <= '0;
            wcnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            pack_q  <= pack_d;
            wcnt_q  <= wcnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        bcnt_d     = bcnt_q;
        pack_d     = pack_q;
        wcnt_d     = wcnt_q;
        ovf_d      = ovf_q;
        rx_ready_o = 1'b0;
        wr_en_o    = 1'b0;
        loading_o  = 1'b0;
        done_o     = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                done_o = (state_q == S_DONE);
                if (start_i) begin
                    state_d = S_CLEAR;
                    idx_d   = '0;
                    wcnt_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_CLEAR: begin
                loading_o = 1'b1;
                wr_en_o   = 1'b1;
                idx_d     = idx_q + 1'b1;
                if (idx_q == '1) begin
                    state_d = S_RECV;
                    idx_d   = '0;
                    bcnt_d  = '0;
                    wcnt_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_RECV: begin
                loading_o  = 1'b1;
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    if (BIG_ENDIAN)
                        pack_d = {pack_q[DATA_WIDTH-9:0], rx_data_i};
                    else
                        pack_d = {rx_data_i, pack_q[DATA_WIDTH-1:8]};
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == 2'd3)
                        state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                loading_o = 1'b1;
                if (wcnt_q == FULL) begin
                    // Memory already full: drop the word and end the session.
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wr_en_o = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    wcnt_d  = wcnt_q + 1'b1;
                    state_d = (pack_q == HALT_WORD) ? S_DONE : S_RECV;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_addr_o    = 32'({idx_q, 2'b00});
    assign wr_data_o    = (state_q == S_CLEAR) ? '0 : pack_q;
    assign word_count_o = wcnt_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: randomized byte streams checked against a word-list model
// of what the memory must receive.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready, wr_en, loading, done, overflow;
    logic [31:0] wr_addr, wr_data;
    logic [8:0]  word_count;

    imem_loader dut (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .loading_o(loading), .done_o(done), .word_count_o(word_count),
        .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t wq[$];
    wr_t mon_e;
    int  n_chk = 0;
    int  n_pass = 0;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            mon_e.a = wr_addr;
            mon_e.d = wr_data;
            wq.push_back(mon_e);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 0;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_data = b; rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (rx_ready === 1'b1) begin ok = 1; tick(); break; end
            tick();
        end
        rx_valid = 1'b0;
        if (!ok) begin n_chk++; $display("FAIL send_byte_timeout byte %h never accepted", b); end
    endtask

    task automatic send_word(input logic [31:0] w, input int gmax);
        logic [31:0] t;
        t = w;
        for (int k = 0; k < 4; k++) send_byte(t[31-8*k -: 8], $urandom_range(0, gmax));
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == 32'hFFFF_FFFF) w = 32'h0000_0013;
        return w;
    endfunction

    // Start a session and verify the full zero-fill before RECV is reached.
    task automatic start_session();
        bit ok = 0;
        int bad = 0;
        wq.delete();
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            if (rx_ready === 1'b1) begin ok = 1; break; end
            tick();
        end
        rx_valid = 1'b0;
        n_chk++; if (!ok) $display("FAIL clear_timeout rx_ready never rose"); else n_pass++;
        n_chk++; if (wq.size() !== 256) $display("FAIL clear_count got %0d exp 256", wq.size()); else n_pass++;
        for (int i = 0; i < wq.size() && i < 256; i++)
            if (wq[i].a !== 32'(4*i) || wq[i].d !== 32'h0) bad++;
        n_chk++; if (bad != 0) $display("FAIL clear_entries got %0d bad exp 0", bad); else n_pass++;
        n_chk++; if ({word_count, overflow, done} !== 11'h0)
            $display("FAIL clear_status got wc=%0d ovf=%b done=%b exp 0", word_count, overflow, done);
        else n_pass++;
        wq.delete();
    endtask

    // Compare the captured writes against the expected word list (word i at byte 4*i).
    task automatic check_writes(input string nm, input logic [31:0] exp[$]);
        int bad = 0;
        n_chk++; if (wq.size() !== exp.size())
            $display("FAIL %s_count got %0d exp %0d", nm, wq.size(), exp.size());
        else n_pass++;
        for (int i = 0; i < wq.size() && i < exp.size(); i++)
            if (wq[i].a !== 32'(4*i) || wq[i].d !== exp[i]) bad++;
        n_chk++; if (bad != 0) $display("FAIL %s_entries got %0d bad exp 0", nm, bad); else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h0;
        repeat (3) tick();
        n_chk++; if (rx_ready !== 1'b0) $display("FAIL reset_rx_ready got %b exp 0", rx_ready); else n_pass++;
        n_chk++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %b exp 0", wr_en); else n_pass++;
        n_chk++; if (wr_addr !== 32'h0) $display("FAIL reset_wr_addr got %h exp 0", wr_addr); else n_pass++;
        n_chk++; if (wr_data !== 32'h0) $display("FAIL reset_wr_data got %h exp 0", wr_data); else n_pass++;
        n_chk++; if (loading !== 1'b0) $display("FAIL reset_loading got %b exp 0", loading); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
        n_chk++; if (word_count !== 9'd0) $display("FAIL reset_word_count got %0d exp 0", word_count); else n_pass++;
        n_chk++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else n_pass++;
        reset = 1'b0;
        repeat (2) tick();
        n_chk++; if ({loading, wr_en} !== 2'b00) $display("FAIL idle_hold got %b exp 00", {loading, wr_en}); else n_pass++;
    endtask

    task automatic test_single_word();
        start_session();
        send_byte(8'h20, 1); send_byte(8'h08, 0); send_byte(8'h00, 2); send_byte(8'h05, 0);
        n_chk++; if (wr_en !== 1'b1) $display("FAIL latency_wr_en got %b exp 1", wr_en); else n_pass++;
        n_chk++; if (wr_addr !== 32'h0) $display("FAIL latency_addr got %h exp 0", wr_addr); else n_pass++;
        n_chk++; if (wr_data !== 32'h2008_0005) $display("FAIL latency_data got %h exp 20080005", wr_data); else n_pass++;
        n_chk++; if (rx_ready !== 1'b0) $display("FAIL write_rx_ready got %b exp 0", rx_ready); else n_pass++;
        tick();
        n_chk++; if ({wr_en, rx_ready} !== 2'b01) $display("FAIL after_write got %b exp 01", {wr_en, rx_ready}); else n_pass++;
    endtask

    task automatic test_halt();
        logic [31:0] exp[$];
        exp = '{32'h2008_0005, 32'h0109_5020, 32'hFFFF_FFFF};
        send_word(32'h0109_5020, 1);
        send_word(32'hFFFF_FFFF, 1);
        tick();
        n_chk++; if (done !== 1'b1) $display("FAIL halt_done got %b exp 1", done); else n_pass++;
        n_chk++; if (word_count !== 9'd3) $display("FAIL halt_word_count got %0d exp 3", word_count); else n_pass++;
        n_chk++; if (loading !== 1'b0) $display("FAIL halt_loading got %b exp 0", loading); else n_pass++;
        check_writes("halt", exp);
    endtask

    task automatic test_random_session();
        for (int r = 0; r < 3; r++) begin
            logic [31:0] exp[$];
            int n;
            start_session();
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) exp.push_back(rand_word());
            exp.push_back(32'hFFFF_FFFF);
            foreach (exp[i]) send_word(exp[i], 2);
            tick();
            n_chk++; if (done !== 1'b1 || word_count !== 9'(n+1))
                $display("FAIL rand_status got done=%b wc=%0d exp done=1 wc=%0d", done, word_count, n+1);
            else n_pass++;
            check_writes("rand", exp);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp[$];
        start_session();
        for (int i = 0; i < 257; i++) begin
            logic [31:0] w;
            w = rand_word();
            if (i < 256) exp.push_back(w);
            send_word(w, 0);
            if (i == 255) begin
                tick();
                n_chk++; if ({rx_ready, done} !== 2'b10)
                    $display("FAIL full_continue got rdy/done=%b exp 10", {rx_ready, done});
                else n_pass++;
            end
        end
        n_chk++; if (wr_en !== 1'b0) $display("FAIL ovf_wr_en got %b exp 0", wr_en); else n_pass++;
        tick();
        n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow); else n_pass++;
        n_chk++; if (done !== 1'b1) $display("FAIL ovf_done got %b exp 1", done); else n_pass++;
        n_chk++; if (word_count !== 9'd256) $display("FAIL ovf_word_count got %0d exp 256", word_count); else n_pass++;
        n_chk++; if (wq.size() > 0 && wq[wq.size()-1].a !== 32'h3FC)
            $display("FAIL ovf_last_addr got %h exp 3fc", wq[wq.size()-1].a);
        else n_pass++;
        check_writes("ovf", exp);
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        start_session();
        send_word(rand_word(), 1); send_word(rand_word(), 1);
        send_byte(8'hA5, 0); send_byte(8'h5A, 1);
        reset = 1'b1; tick();
        n_chk++; if ({rx_ready, wr_en, wr_addr, wr_data, loading, done, word_count, overflow} !== '0)
            $display("FAIL midreset_outputs got rdy=%b we=%b a=%h d=%h ld=%b dn=%b wc=%0d ov=%b exp all 0",
                     rx_ready, wr_en, wr_addr, wr_data, loading, done, word_count, overflow);
        else n_pass++;
        reset = 1'b0; tick();
        start_session();
        w = rand_word();
        send_word(w, 1);
        n_chk++; if (wr_en !== 1'b1 || wr_addr !== 32'h0 || wr_data !== w)
            $display("FAIL midreset_first got we=%b a=%h d=%h exp 1/0/%h", wr_en, wr_addr, wr_data, w);
        else n_pass++;
        tick();
    endtask

    task automatic test_ignore();
        logic [31:0] x, z;
        logic [31:0] ys[$];
        logic [31:0] exp[$];
        int nb = 0;
        x = rand_word();
        // start during RECV must not restart the session
        send_byte(x[31:24], 0); send_byte(x[23:16], 0);
        wq.delete();
        pulse_start();
        tick();
        n_chk++; if ({rx_ready, loading, wr_en} !== 3'b110 || wq.size() != 0)
            $display("FAIL start_in_recv got rdy/ld/we=%b writes=%0d exp 110 0", {rx_ready, loading, wr_en}, wq.size());
        else n_pass++;
        send_byte(x[15:8], 1); send_byte(x[7:0], 0);
        n_chk++; if (wr_addr !== 32'h4 || wr_data !== x)
            $display("FAIL resume_word got a=%h d=%h exp 4 %h", wr_addr, wr_data, x);
        else n_pass++;
        tick();
        // rx_valid held high: junk presented whenever rx_ready is low must be dropped
        ys = '{rand_word(), rand_word(), 32'hFFFF_FFFF};
        wq.delete();
        rx_valid = 1'b1;
        foreach (ys[i]) for (int k = 0; k < 4; k++) begin
            logic [31:0] t;
            bit ok = 0;
            t = ys[i];
            for (int c = 0; c < 20; c++) begin
                if (rx_ready === 1'b1) begin rx_data = t[31-8*k -: 8]; ok = 1; tick(); break; end
                rx_data = 8'hEE; tick();
            end
            if (ok) nb++;
        end
        rx_data = 8'hEE;
        repeat (5) tick();
        n_chk++; if (nb != 12) $display("FAIL stream_accept got %0d exp 12", nb); else n_pass++;
        n_chk++; if ({done, rx_ready, wr_en} !== 3'b100 || word_count !== 9'd5)
            $display("FAIL done_hold got dn/rdy/we=%b wc=%0d exp 100 5", {done, rx_ready, wr_en}, word_count);
        else n_pass++;
        exp = ys;
        n_chk++; if (wq.size() != 3 || wq[0].d !== exp[0] || wq[1].d !== exp[1] || wq[2].a !== 32'h10)
            $display("FAIL stream_writes got n=%0d exp 3 (%h %h)", wq.size(), exp[0], exp[1]);
        else n_pass++;
        // bytes offered throughout CLEAR must not leak into the first word
        rx_data = 8'hAA;
        start_session();
        z = rand_word();
        send_word(z, 0);
        n_chk++; if (wr_addr !== 32'h0 || wr_data !== z)
            $display("FAIL clear_drop got a=%h d=%h exp 0 %h", wr_addr, wr_data, z);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_halt();
        test_random_session();
        test_overflow();
        test_reset_mid();
        test_ignore();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1);
    end

endmodule
